// File: rtl/psum_accumulator.sv
// Row accumulator for systolic-array partial sums: adds tile_count psum vectors per row
// with per-lane saturation and hands finished rows out through a single-entry output register.
module psum_accumulator #(
    parameter int ARRAY_SIZE = 8,
    parameter int PSUM_W     = 32,
    parameter int ACC_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [7:0]                  tile_count,
    input  logic [7:0]                  row_count,
    input  logic                        is_signed,
    input  logic                        psum_valid,
    output logic                        psum_ready,
    input  logic [ARRAY_SIZE*PSUM_W-1:0] psums,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ARRAY_SIZE*ACC_W-1:0] out_data,
    output logic [ARRAY_SIZE-1:0]       out_sat,
    output logic                        busy
);

    localparam int EXT_W = ((ACC_W > PSUM_W) ? ACC_W : PSUM_W) + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [7:0]                     tile_q, tile_d;
    logic [7:0]                     rows_q, rows_d;
    logic                           signed_q, signed_d;
    logic [7:0]                     beat_q, beat_d;
    logic [7:0]                     row_idx_q, row_idx_d;
    logic [ARRAY_SIZE*ACC_W-1:0]    acc_q, acc_d;
    logic [ARRAY_SIZE-1:0]          sat_q, sat_d;
    logic                           out_valid_q, out_valid_d;
    logic [ARRAY_SIZE*ACC_W-1:0]    out_data_q, out_data_d;
    logic [ARRAY_SIZE-1:0]          out_sat_q, out_sat_d;
    logic                           psum_ready_q;
    logic                           busy_q;

    logic [ARRAY_SIZE*ACC_W-1:0]    sum_s;
    logic [ARRAY_SIZE-1:0]          lane_sat_s;
    logic                           consume_s;
    logic                           load_s;
    logic [ARRAY_SIZE*ACC_W-1:0]    load_data_s;
    logic [ARRAY_SIZE-1:0]          load_sat_s;
    logic [7:0]                     beat_next_s;

    // Saturating add; result is {clamped, value}. Operands widened so the raw sum never wraps.
    function automatic logic [ACC_W:0] sat_add(
        input logic [ACC_W-1:0]  acc,
        input logic [PSUM_W-1:0] p,
        input logic              sgn
    );
        logic signed [EXT_W-1:0] a_x;
        logic signed [EXT_W-1:0] p_x;
        logic signed [EXT_W-1:0] sum_v;
        logic signed [EXT_W-1:0] max_v;
        logic signed [EXT_W-1:0] min_v;
        a_x = {{(EXT_W-ACC_W){sgn & acc[ACC_W-1]}}, acc};
        p_x = {{(EXT_W-PSUM_W){sgn & p[PSUM_W-1]}}, p};
        sum_v = a_x + p_x;
        if (sgn) begin
            max_v = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
            min_v = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
        end else begin
            max_v = {{(EXT_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
            min_v = {EXT_W{1'b0}};
        end
        if (sum_v > max_v) begin
            sat_add = {1'b1, max_v[ACC_W-1:0]};
        end else if (sum_v < min_v) begin
            sat_add = {1'b1, min_v[ACC_W-1:0]};
        end else begin
            sat_add = {1'b0, sum_v[ACC_W-1:0]};
        end
    endfunction

    // Per-lane saturating sum of the accumulators and the incoming psum vector.
    always_comb begin
        sum_s      = '0;
        lane_sat_s = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            {lane_sat_s[i], sum_s[i*ACC_W +: ACC_W]} =
                sat_add(acc_q[i*ACC_W +: ACC_W], psums[i*PSUM_W +: PSUM_W], signed_q);
        end
    end

    // Next-state, accumulator and output-register control.
    always_comb begin
        state_d     = state_q;
        tile_d      = tile_q;
        rows_d      = rows_q;
        signed_d    = signed_q;
        beat_d      = beat_q;
        row_idx_d   = row_idx_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        consume_s   = out_valid_q & out_ready;
        load_s      = 1'b0;
        load_data_s = acc_q;
        load_sat_s  = sat_q;
        beat_next_s = beat_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ACCUM;
                    tile_d    = (tile_count == 8'd0) ? 8'd1 : tile_count;
                    rows_d    = (row_count == 8'd0) ? 8'd1 : row_count;
                    signed_d  = is_signed;
                    beat_d    = 8'd0;
                    row_idx_d = 8'd0;
                    acc_d     = '0;
                    sat_d     = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (psum_valid) begin
                    beat_d = beat_next_s;
                    if (beat_next_s == tile_q) begin
                        if (!out_valid_q || consume_s) begin
                            load_s      = 1'b1;
                            load_data_s = sum_s;
                            load_sat_s  = sat_q | lane_sat_s;
                        end else begin
                            state_d = S_HOLD;
                            acc_d   = sum_s;
                            sat_d   = sat_q | lane_sat_s;
                        end
                    end else begin
                        acc_d = sum_s;
                        sat_d = sat_q | lane_sat_s;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_HOLD: begin
                if (consume_s) begin
                    load_s = 1'b1;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A load refills the output register at the same edge it is drained, so out_valid stays high.
        if (load_s) begin
            out_data_d  = load_data_s;
            out_sat_d   = load_sat_s;
            out_valid_d = 1'b1;
            if (row_idx_q == rows_q - 8'd1) begin
                state_d = S_IDLE;
            end else begin
                state_d   = S_ACCUM;
                acc_d     = '0;
                sat_d     = '0;
                beat_d    = 8'd0;
                row_idx_d = row_idx_q + 8'd1;
            end
        end else if (consume_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tile_q       <= 8'd0;
            rows_q       <= 8'd0;
            signed_q     <= 1'b0;
            beat_q       <= 8'd0;
            row_idx_q    <= 8'd0;
            acc_q        <= '0;
            sat_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sat_q    <= '0;
            psum_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tile_q       <= tile_d;
            rows_q       <= rows_d;
            signed_q     <= signed_d;
            beat_q       <= beat_d;
            row_idx_q    <= row_idx_d;
            acc_q        <= acc_d;
            sat_q        <= sat_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sat_q    <= out_sat_d;
            psum_ready_q <= (state_d == S_ACCUM);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign psum_ready = psum_ready_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;

endmodule
